// File: rtl/room_pkg.sv
// ============================================================================
//  Module      : room_pkg
//  Description : Shared types and helpers for the room actuator: state
//                encoding, temperature width, clamp and distance helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package room_pkg;

  localparam int TEMP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAT = 2'd1,
    COOL = 2'd2,
    HOLD = 2'd3
  } room_state_e;

  // Limit a requested temperature to the accepted setpoint window.
  function automatic logic [TEMP_W-1:0] clamp_temp(input logic [TEMP_W-1:0] v,
                                                   input logic [TEMP_W-1:0] lo,
                                                   input logic [TEMP_W-1:0] hi);
    if (v < lo)      clamp_temp = lo;
    else if (v > hi) clamp_temp = hi;
    else             clamp_temp = v;
  endfunction

  // Unsigned distance between two temperatures (never wraps).
  function automatic logic [TEMP_W-1:0] abs_diff(input logic [TEMP_W-1:0] a,
                                                 input logic [TEMP_W-1:0] b);
    abs_diff = (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

`default_nettype wire

// File: rtl/room_step_timer.sv
// ============================================================================
//  Module      : room_step_timer
//  Description : Counts STEP_CYCLES enabled cycles and pulses tick on the
//                last one; clear forces the count back to zero so each ramp
//                starts with a full step period.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module room_step_timer #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] c_last = 8'(STEP_CYCLES - 1);

  logic [7:0] r_cnt;
  logic       w_last;

  assign w_last = (r_cnt == c_last);
  assign tick   = en && !clear && w_last;

  // Free-running step counter while enabled, wrapping after each step.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= 8'd0;
    end else if (en) begin
      if (w_last) r_cnt <= 8'd0;
      else        r_cnt <= r_cnt + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/room_actuator.sv
// ============================================================================
//  Module      : room_actuator
//  Description : Models a room heated/cooled toward an accepted setpoint at
//                one degree per STEP_CYCLES clocks, pulsing done on arrival.
//                Optional build macro ROOM_ACT_DEADBAND_EN: treat targets
//                within DEADBAND degrees as reached.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module room_actuator
  import room_pkg::*;
#(
  parameter int INIT_TEMP   = 21,
  parameter int MIN_TEMP    = 16,
  parameter int MAX_TEMP    = 30,
  parameter int STEP_CYCLES = 4,
  parameter int DEADBAND    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic              sp_valid,
  output logic              sp_ready,
  output logic [TEMP_W-1:0] cur_temp,
  output logic              heat_on,
  output logic              cool_on,
  output logic              done
);

  localparam logic [TEMP_W-1:0] c_init = TEMP_W'(INIT_TEMP);
  localparam logic [TEMP_W-1:0] c_min  = TEMP_W'(MIN_TEMP);
  localparam logic [TEMP_W-1:0] c_max  = TEMP_W'(MAX_TEMP);
`ifdef ROOM_ACT_DEADBAND_EN
  localparam logic [TEMP_W-1:0] c_tol  = TEMP_W'(DEADBAND);
`else
  // Exact arrival required; the tolerance collapses to zero.
  localparam logic [TEMP_W-1:0] c_tol  = TEMP_W'(0 * DEADBAND);
`endif

  room_state_e       r_state, w_next;
  logic [TEMP_W-1:0] r_cur, r_target;
  logic              r_done;
  logic [TEMP_W-1:0] w_sp_clamp, w_next_temp;
  logic              w_load, w_done, w_ramping, w_tick;

  assign w_sp_clamp  = clamp_temp(setpoint, c_min, c_max);
  assign w_next_temp = (r_state == HEAT) ? (r_cur + 8'd1) : (r_cur - 8'd1);
  assign w_ramping   = (r_state == HEAT) || (r_state == COOL);

  room_step_timer #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (w_ramping),
    .clear (!w_ramping),
    .tick  (w_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: accept in IDLE/HOLD, stop a ramp once the target is reached.
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_done = 1'b0;
    case (r_state)
      IDLE, HOLD: begin
        if (sp_valid) begin
          w_load = 1'b1;
          if (abs_diff(w_sp_clamp, r_cur) <= c_tol) begin
            w_next = HOLD;
            w_done = 1'b1;
          end else if (w_sp_clamp > r_cur) begin
            w_next = HEAT;
          end else begin
            w_next = COOL;
          end
        end
      end
      HEAT, COOL: begin
        if (w_tick && (abs_diff(r_target, w_next_temp) <= c_tol)) begin
          w_next = HOLD;
          w_done = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    sp_ready = (r_state == IDLE) || (r_state == HOLD);
    heat_on  = (r_state == HEAT);
    cool_on  = (r_state == COOL);
  end

  // Temperature, target and done-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur    <= c_init;
      r_target <= c_init;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_load) r_target <= w_sp_clamp;
      if (w_tick) r_cur    <= w_next_temp;
    end
  end

  assign cur_temp = r_cur;
  assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_room_actuator.sv
// ============================================================================
//  Module      : tb_room_actuator
//  Description : Randomised scoreboard bench for room_actuator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_room_actuator;

  localparam int S    = 4;
  localparam int INIT = 21;
  localparam int LO   = 16;
  localparam int HI   = 30;
`ifdef ROOM_ACT_DEADBAND_EN
  localparam int TOL  = 1;
`else
  localparam int TOL  = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sp_valid = 1'b0;
  logic [7:0] setpoint = 8'd0;
  logic       sp_ready, heat_on, cool_on, done;
  logic [7:0] cur_temp;

  room_actuator dut (
    .clk      (clk),
    .rst      (rst),
    .setpoint (setpoint),
    .sp_valid (sp_valid),
    .sp_ready (sp_ready),
    .cur_temp (cur_temp),
    .heat_on  (heat_on),
    .cool_on  (cool_on),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; int t; } ev_t;
  ev_t temp_q[$];
  ev_t done_q[$];

  int total = 0;
  int bad   = 0;
  int exp_cur = INIT;
  int busy_until = 0;
  int rs = 0, re = 0, rdir = 0;
  bit mon_on = 0, mon_skip = 0;
  int prev_temp = INIT;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, req, cyc);
    end
  endtask

  task automatic fail(input string nm, input int act, input int req);
    total++;
    bad++;
    $display("FAIL %s actual=%0d required=%0d cycle=%0d", nm, act, req, cyc);
  endtask

  // Reference model: predicts every temperature step and the done pulse.
  task automatic issue(input int v);
    int a, t, mag, dir, n;
    @(negedge clk);
    while (cyc < busy_until) @(negedge clk);
    sp_valid = 1'b1;
    setpoint = 8'(v);
    @(posedge clk);
    #1;
    a = cyc;
    sp_valid = 1'b0;
    t   = (v < LO) ? LO : ((v > HI) ? HI : v);
    mag = (t > exp_cur) ? (t - exp_cur) : (exp_cur - t);
    dir = (t > exp_cur) ? 1 : -1;
    if (mag <= TOL) begin
      done_q.push_back('{a, exp_cur});
      busy_until = a;
    end else begin
      n = mag - TOL;
      for (int k = 1; k <= n; k++) temp_q.push_back('{a + k * S, exp_cur + dir * k});
      done_q.push_back('{a + n * S, exp_cur + dir * n});
      rs = a;
      re = a + n * S;
      rdir = dir;
      exp_cur = exp_cur + dir * n;
      busy_until = re;
    end
  endtask

  task automatic ignore_burst(input int n, input int v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cyc < busy_until) begin
        sp_valid = 1'b1;
        setpoint = 8'(v);
      end else begin
        sp_valid = 1'b0;
      end
    end
    @(negedge clk);
    sp_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    temp_q.delete();
    done_q.delete();
    exp_cur = INIT;
    busy_until = cyc;
    rs = 0;
    re = 0;
    mon_skip = 1;
    chk("rst_cur_temp", int'(cur_temp), INIT);
    chk("rst_sp_ready", int'(sp_ready), 1);
    chk("rst_heat_on", int'(heat_on), 0);
    chk("rst_cool_on", int'(cool_on), 0);
    chk("rst_done", int'(done), 0);
  endtask

  // Monitor: pops expected events whenever the DUT shows a change or a pulse.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      if (mon_skip) begin
        prev_temp = int'(cur_temp);
        mon_skip = 0;
      end else begin
        ev_t ev;
        bit  ramp;
        while (temp_q.size() > 0 && temp_q[0].c < cyc) begin
          ev = temp_q.pop_front();
          fail("temp_step_missing", int'(cur_temp), ev.t);
        end
        while (done_q.size() > 0 && done_q[0].c < cyc) begin
          ev = done_q.pop_front();
          fail("done_missing", 0, 1);
        end
        if (int'(cur_temp) != prev_temp) begin
          if (temp_q.size() == 0) begin
            fail("temp_unexpected", int'(cur_temp), prev_temp);
          end else begin
            ev = temp_q.pop_front();
            chk("temp_value", int'(cur_temp), ev.t);
            chk("temp_cycle", cyc, ev.c);
          end
          prev_temp = int'(cur_temp);
        end
        if (done) begin
          if (done_q.size() == 0) begin
            fail("done_unexpected", 1, 0);
          end else begin
            ev = done_q.pop_front();
            chk("done_cycle", cyc, ev.c);
            chk("done_temp", int'(cur_temp), ev.t);
          end
        end
        ramp = (cyc >= rs) && (cyc < re);
        chk("heat_on", int'(heat_on), int'(ramp && rdir > 0));
        chk("cool_on", int'(cool_on), int'(ramp && rdir < 0));
        chk("sp_ready", int'(sp_ready), int'(!ramp));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    do_reset();
    mon_on = 1;

    // Directed: heat, cool, no-move, clamps.
    issue(24);
    issue(18);
    issue(21);
    issue(21);
    issue(36);
    issue(0);

    // Setpoints offered mid-ramp must be ignored.
    issue(24);
    ignore_burst(5, 18);

    // Reset part-way through a ramp.
    issue(30);
    repeat (6) @(negedge clk);
    do_reset();

    // Near targets (deadband behaviour when enabled).
    issue(22);
    do_reset();
    issue(25);

    // Randomised traffic.
    for (int i = 0; i < 30; i++) begin
      issue(int'($urandom_range(0, 40)));
      r = int'($urandom_range(0, 9));
      if (r < 3) begin
        ignore_burst(int'($urandom_range(1, 6)), int'($urandom_range(0, 255)));
      end else if (r == 3) begin
        repeat (int'($urandom_range(0, 10))) @(negedge clk);
        do_reset();
      end
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    @(negedge clk);
    while (cyc < busy_until + 3) @(negedge clk);
    chk("temp_events_left", temp_q.size(), 0);
    chk("done_events_left", done_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/room_actuator.md
ROOM_ACTUATOR -- requirements
Module: room_actuator

Interface
REQ-001 SHALL have parameter INIT_TEMP, default 21: room temperature (degC) loaded at reset.
REQ-002 SHALL have parameter MIN_TEMP, default 16: lowest accepted setpoint.
REQ-003 SHALL have parameter MAX_TEMP, default 30: highest accepted setpoint.
REQ-004 SHALL have parameter STEP_CYCLES, default 4: clock cycles per 1 degC ramp step, legal range 1..255.
REQ-005 SHALL have parameter DEADBAND, default 1: hold tolerance in degC, used only when ROOM_ACT_DEADBAND_EN is defined.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port setpoint, input, 8: unsigned target room temperature from the regulator's finalRoom output.
REQ-009 SHALL have port sp_valid, input, 1: setpoint is valid this cycle.
REQ-010 SHALL have port sp_ready, output, 1: actuator accepts a setpoint this cycle.
REQ-011 SHALL have port cur_temp, output, 8: modelled room temperature.
REQ-012 SHALL have port heat_on, output, 1: high in HEAT.
REQ-013 SHALL have port cool_on, output, 1: high in COOL.
REQ-014 SHALL have port done, output, 1: one-cycle pulse when the target is reached.

Function
REQ-015 SHALL implement FSM states IDLE, HEAT, COOL, HOLD.
REQ-016 SHALL drive sp_ready=1 in IDLE and HOLD and sp_ready=0 in HEAT and COOL; sp_valid while sp_ready=0 is ignored, not queued.
REQ-017 SHALL register on accept (sp_valid & sp_ready) target = clamp(setpoint, MIN_TEMP, MAX_TEMP).
REQ-018 SHALL move, on the cycle after accept, to HEAT if target>cur_temp, COOL if target<cur_temp, else HOLD with done=1 on that cycle.
REQ-019 SHALL, in HEAT/COOL, run a step timer that counts STEP_CYCLES cycles and then increments or decrements cur_temp by exactly 1, restarting at 0 on every entry to HEAT/COOL.
REQ-020 SHALL, on the cycle cur_temp becomes equal to target, enter HOLD and pulse done for exactly one cycle.
REQ-021 SHALL keep cur_temp within 0..255 with no wrap; clamping to MIN_TEMP..MAX_TEMP guarantees that.
REQ-022 SHALL keep heat_on and cool_on mutually exclusive and 0 in IDLE/HOLD.
REQ-023 SHALL take the first ramp step for a 1-degree move exactly STEP_CYCLES cycles after entering HEAT/COOL; total ramp latency = |target-cur_temp|*STEP_CYCLES cycles.

Reset
REQ-024 SHALL, with rst=1 at a clock edge, set state=IDLE, cur_temp=INIT_TEMP, target=INIT_TEMP, timer=0, heat_on=0, cool_on=0, done=0, sp_ready=1 on the next cycle.
REQ-025 SHALL abort any ramp on reset, discarding the in-progress partial step.

Configuration
REQ-026 SHALL, with ROOM_ACT_DEADBAND_EN defined, treat |target-cur_temp|<=DEADBAND as reached, both at accept (direct HOLD, done) and during ramp (stop early, done).
REQ-027 SHALL, without ROOM_ACT_DEADBAND_EN, require exact equality and ignore DEADBAND.

Structure
REQ-028 SHALL place the state enum, TEMP_W=8 and the clamp function in shared package room_pkg.
REQ-029 SHALL implement the step timer as sub-module room_step_timer (inputs clk, rst, en, clear; output tick).

Verification (defaults, macro undefined unless stated)
REQ-030 SHALL check reset -> cur_temp=21, sp_ready=1, heat_on=cool_on=done=0.
REQ-031 SHALL check setpoint=24 accepted -> HEAT, cur_temp 22/23/24 at 4-cycle intervals, done one cycle at 24, then HOLD.
REQ-032 SHALL check setpoint=18 from 21 -> cool_on=1, three decrements over 12 cycles, done at 18; setpoint=21 from 21 -> done the next cycle, no heat/cool.
REQ-033 SHALL check setpoint=36 -> clamped to 30, nine steps; setpoint=0 -> clamped to 16.
REQ-034 SHALL check sp_valid with setpoint=18 mid-ramp toward 24 is ignored; rst asserted mid-ramp -> cur_temp=21, IDLE next cycle.
REQ-035 SHALL check that with ROOM_ACT_DEADBAND_EN defined, setpoint=22 from 21 -> immediate HOLD+done, and setpoint=25 -> ramp stops at 24 with done.
